// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the width helpers used to size the address counter and the accumulator.
package dot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } dot_state_e;

  // Ceiling log2 with a floor of 1, so a single-element vector still gets a
  // one-bit address.
  function automatic int dot_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Sum of up to 2**addr_w products of two data_w-bit operands fits in
  // 2*data_w + addr_w bits, so the accumulator can never overflow.
  function automatic int dot_acc_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/dot_mac_stage.sv
// Two-stage multiply-accumulate datapath: a registered product stage followed
// by the accumulator, each with a valid bit that follows the read strobe.
// Build option: DOT_SIGNED_EN makes operands and products two's complement;
// the product is then sign-extended instead of zero-extended before the add.
module dot_mac_stage
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = dot_acc_width(8, 5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,     // synchronous flush of valids and sum
  input  logic                  en_i,        // read issued this cycle
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic [1:0]            stage_vld_o  // [0]: read data valid, [1]: product valid
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        prod_d, prod_q;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 vld0_q, vld1_q;

  // Full-width product of the returned elements and the next accumulator value.
  always_comb begin
`ifdef DOT_SIGNED_EN
    prod_d   = $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i}) *
               $signed({{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i});
    prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
`else
    prod_d   = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    prod_ext = {{(ACC_WIDTH-PW){1'b0}}, prod_q};
`endif
    acc_d = acc_q + prod_ext;
  end

  // Product register, accumulator and the valid bits that track them.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge values of the others.
    if (!rst_n) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
    end else if (clear_i) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      vld0_q <= en_i;
      vld1_q <= vld0_q;
      if (vld0_q) prod_q <= prod_d;
      if (vld1_q) acc_q  <= acc_d;
    end
  end

  assign acc_o       = acc_q;
  assign stage_vld_o = {vld1_q, vld0_q};

endmodule

// File: rtl/dot_seq_ctrl.sv
// Dot-product pass sequencer: walks the A/B memories once per start, feeds the
// MAC datapath and holds the sum on a valid/ready port until it is taken.
// Build option: DOT_SIGNED_EN selects signed arithmetic in dot_mac_stage;
// FSM and timing are the same in both builds.
module dot_seq_ctrl
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 32,
  parameter int ADDR_WIDTH = dot_clog2(VEC_LEN),
  parameter int ACC_WIDTH  = dot_acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] dout_a,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VEC_LEN - 1);

  dot_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
  logic                  acc_clr;
  logic [1:0]            stage_vld;

  // Next state, next read address and datapath flush.
  always_comb begin
    // NOTE: defaults first, so every path through the case assigns each signal and no latch is inferred.
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    acc_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rd_addr_d = '0;
        if (start && !abort) begin
          state_d = ST_READ;
          acc_clr = 1'b1;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rd_addr_d = '0;
          acc_clr   = 1'b1;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Last product sits in the product register with nothing behind it:
        // it is summed on this edge, so the result is complete in HOLD.
        if (abort) begin
          state_d   = ST_IDLE;
          rd_addr_d = '0;
          acc_clr   = 1'b1;
        end else if (stage_vld[1] && !stage_vld[0]) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (result_ready || abort) begin
          state_d   = ST_IDLE;
          rd_addr_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rd_addr_d = '0;
      end
    endcase
  end

  // State register and read address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign rd_en        = (state_q == ST_READ);
  assign rd_addr      = rd_addr_q;
  assign result_valid = (state_q == ST_HOLD);

  dot_mac_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (acc_clr),
    .en_i        (rd_en),
    .a_i         (dout_a),
    .b_i         (dout_b),
    .acc_o       (result),
    .stage_vld_o (stage_vld)
  );

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Self-checking bench for dot_seq_ctrl: VEC_LEN=4 instance with a table of
// hand vectors plus random passes against a sum-of-products model, control
// corner cases (hold, abort, reset mid-pass), and a VEC_LEN=1 instance.
module tb_dot_seq_ctrl;

  localparam int DW  = 8;
  localparam int VL  = 4;
  localparam int AW  = 2;
  localparam int ACW = 18;

  logic           clk;
  logic           rst_n;
  logic           start, abort, result_ready;
  logic           busy, rd_en, result_valid;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  dout_a, dout_b;
  logic [ACW-1:0] result;

  // Second instance: single-element vectors.
  logic           start1, abort1, result_ready1;
  logic           busy1, rd_en1, result_valid1;
  logic [0:0]     rd_addr1;
  logic [DW-1:0]  dout1_a, dout1_b;
  logic [16:0]    result1;

  logic [DW-1:0]  mem_a [VL];
  logic [DW-1:0]  mem_b [VL];
  logic [DW-1:0]  mem1_a, mem1_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [VL-1:0][DW-1:0] a;
    logic [VL-1:0][DW-1:0] b;
    logic [ACW-1:0]        exp;
  } vec_t;

  vec_t vecs [6];

  dot_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout_a(dout_a), .dout_b(dout_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  dot_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .dout_a(dout1_a), .dout_b(dout1_b),
    .result(result1), .result_valid(result_valid1), .result_ready(result_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      dout_a <= mem_a[rd_addr];
      dout_b <= mem_b[rd_addr];
    end
    if (rd_en1) begin
      dout1_a <= mem1_a;
      dout1_b <= mem1_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of element products in plain integer arithmetic.
  function automatic logic [ACW-1:0] dot_model(input logic [VL-1:0][DW-1:0] a,
                                               input logic [VL-1:0][DW-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < VL; i++) begin
`ifdef DOT_SIGNED_EN
      s += longint'($signed(a[i])) * longint'($signed(b[i]));
`else
      s += longint'(a[i]) * longint'(b[i]);
`endif
    end
    return ACW'(s);
  endfunction

  // One pass: start at E0, record issued addresses, measure latency, check sum.
  task automatic run_pass(input logic [VL-1:0][DW-1:0] a, input logic [VL-1:0][DW-1:0] b,
                          input logic [ACW-1:0] exp, input string name, input bit consume);
    int    addrs [$];
    int    first_e;
    int    e;
    bit    seq_ok;
    for (int i = 0; i < VL; i++) begin
      mem_a[i] = a[i];
      mem_b[i] = b[i];
    end
    start = 1'b1;
    tick();
    start   = 1'b0;
    first_e = -1;
    e       = 0;
    while (e < 40) begin
      if (rd_en) begin
        addrs.push_back(int'(rd_addr));
        if (first_e < 0) first_e = e;
      end
      if (result_valid) break;
      tick();
      e++;
    end
    seq_ok = (first_e == 0) && (addrs.size() == VL);
    if (seq_ok) begin
      for (int i = 0; i < VL; i++) if (addrs[i] != i) seq_ok = 1'b0;
    end
    check({name, "_reads"}, 32'(addrs.size()), VL);
    check({name, "_addr_seq"}, 32'(seq_ok), 1);
    check({name, "_latency"}, 32'(e), VL + 2);
    check({name, "_result"}, 32'(result), 32'(exp));
    if (consume) begin
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check({name, "_idle_after"}, {30'd0, busy, result_valid}, 0);
      check({name, "_addr_idle"}, 32'(rd_addr), 0);
    end
  endtask

  logic [VL-1:0][DW-1:0] va, vb, ones_a, ones_b;
  logic [ACW-1:0]        held;
  bit                    ok;
  int                    e;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; result_ready1 = 1'b0;
    mem1_a = '0; mem1_b = '0;
    for (int i = 0; i < VL; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    va     = {8'd4, 8'd3, 8'd2, 8'd1};
    vb     = {8'd8, 8'd7, 8'd6, 8'd5};
    ones_a = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ones_b = {8'hFF, 8'hFF, 8'hFF, 8'hFF};

    vecs[0] = '{a: va, b: vb, exp: 18'd70};
`ifdef DOT_SIGNED_EN
    vecs[1] = '{a: ones_a, b: ones_b, exp: 18'd4};
    vecs[2] = '{a: {8'd4, 8'd3, 8'hFE, 8'hFF}, b: vb, exp: 18'd36};
`else
    vecs[1] = '{a: ones_a, b: ones_b, exp: 18'd260100};
    vecs[2] = '{a: {8'd4, 8'd3, 8'hFE, 8'hFF}, b: vb, exp: 18'd2852};
`endif
    for (int r = 3; r < 6; r++) begin
      vecs[r].a   = {$urandom, $urandom} & 32'hFFFF_FFFF;
      vecs[r].b   = $urandom;
      vecs[r].exp = dot_model(vecs[r].a, vecs[r].b);
    end

    // Reset state.
    #12;
    check("reset_ctrl", {29'd0, busy, rd_en, result_valid}, 0);
    check("reset_addr", 32'(rd_addr), 0);
    check("reset_result", 32'(result), 0);
    #6 rst_n = 1'b1;
    tick();

    // Table vectors.
    for (int r = 0; r < 6; r++) begin
      run_pass(vecs[r].a, vecs[r].b, vecs[r].exp, $sformatf("vec%0d", r), 1'b1);
    end

    // Random passes against the model.
    for (int r = 0; r < 12; r++) begin
      logic [VL-1:0][DW-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      run_pass(ra, rb, dot_model(ra, rb), $sformatf("rand%0d", r), 1'b1);
    end

    // Hold with ready low; start pulsed during HOLD must be ignored.
    run_pass(va, vb, 18'd70, "hold", 1'b0);
    held = result;
    ok   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      if (result !== held || !busy || rd_en || !result_valid) ok = 1'b0;
    end
    start = 1'b0;
    check("hold_stable", 32'(ok), 1);
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    check("hold_release", {30'd0, busy, result_valid}, 0);
    tick();
    check("hold_start_ignored", {30'd0, busy, rd_en}, 0);

    // Abort while rd_addr=2.
    for (int i = 0; i < VL; i++) begin
      mem_a[i] = va[i];
      mem_b[i] = vb[i];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    while (rd_addr != 2'd2 && e < 10) begin
      tick();
      e++;
    end
    check("abort_reach_addr2", 32'(rd_addr), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {30'd0, busy, rd_en}, 0);
    check("abort_addr", 32'(rd_addr), 0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid || busy) ok = 1'b1;
    end
    check("abort_no_result", 32'(ok), 0);
    run_pass(va, vb, 18'd70, "after_abort", 1'b1);

    // Abort in HOLD with start in the same cycle: result dropped, no new pass.
    run_pass(va, vb, 18'd70, "hold_abort", 1'b0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("hold_abort_idle", {30'd0, busy, result_valid}, 0);
    tick();
    check("hold_abort_no_start", {30'd0, busy, rd_en}, 0);

    // Abort and start together in IDLE: start ignored.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("idle_abort_start", {30'd0, busy, rd_en}, 0);

    // Reset asserted mid-READ, after the first product has been summed.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_in_read", 32'(rd_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {29'd0, busy, rd_en, result_valid}, 0);
    check("midreset_addr", 32'(rd_addr), 0);
    check("midreset_result", 32'(result), 0);
    #2 rst_n = 1'b1;
    tick();
    run_pass(va, vb, 18'd70, "after_reset", 1'b1);

    // VEC_LEN=1 instance: one read, result at E3.
    mem1_a = 8'd200;
    mem1_b = 8'd3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("v1_read", {30'd0, rd_en1, rd_addr1}, 32'd2);
    e = 0;
    while (!result_valid1 && e < 20) begin
      tick();
      e++;
    end
    check("v1_latency", 32'(e), 3);
`ifdef DOT_SIGNED_EN
    check("v1_result", 32'(result1), 32'(17'h1FF58));
`else
    check("v1_result", 32'(result1), 600);
`endif
    result_ready1 = 1'b1;
    tick();
    result_ready1 = 1'b0;
    check("v1_idle", {30'd0, busy1, result_valid1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
